lzd64_seq_ctrl: RTL

LZD64_SEQ_CTRL -- requirements
Module: lzd64_seq_ctrl

---
 rtl/lzd64_seq_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/lzd64_seq_ctrl.sv
// -----------------------------------------------------------------------------
// lzd64_seq_ctrl
// Sequential 64-bit leading-zero detector and normaliser. An accepted operand
// is scanned one 16-bit chunk per cycle, MSB chunk first, through a single
// shared 16-bit leading-zero detector. The first nonzero chunk ends the scan
// and a one-cycle barrel shift produces the normalised result. An all-zero
// operand finishes with count 64, out_zero=1 and out_norm=0.
//
// Build option:
//   LZD64_ZERO_BYPASS_EN - when defined, an all-zero operand is recognised in
//                          the first SCAN cycle and goes straight to DONE, so
//                          out_valid rises one edge after the accept edge.
//                          Nonzero operands behave identically in both builds.
//
// Ports:
//   clk       in   1   clock, rising edge
//   rst_n     in   1   asynchronous active-low reset
//   in_valid  in   1   operand offered
//   in_ready  out  1   high in IDLE; operand taken on in_valid && in_ready
//   in_data   in  64   operand, bit 63 = MSB
//   out_valid out  1   high in DONE; result held until out_ready
//   out_ready in   1   consumer takes result on out_valid && out_ready
//   out_count out  7   leading-zero count, 0..64
//   out_norm  out 64   operand << out_count (0 for a zero operand)
//   out_zero  out  1   operand was all zeros
//   busy      out  1   high in any state other than IDLE
// -----------------------------------------------------------------------------
module lzd64_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_count,
    output logic [63:0] out_norm,
    output logic        out_zero,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Leading-zero count of a 16-bit chunk; only meaningful for nonzero input.
    function automatic logic [4:0] lzc16(input logic [15:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd16;
        found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(15 - i);
                found = 1'b1;
            end else begin
                n     = n;
            end
        end
        return n;
    endfunction

    state_t      state_r;
    state_t      state_nx_s;
    logic [63:0] data_r;
    logic [1:0]  idx_r;
    logic [6:0]  count_r;
    logic [6:0]  out_count_r;
    logic [63:0] out_norm_r;
    logic        out_zero_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic        busy_r;

    logic [15:0] chunk_s;
    logic [4:0]  lzc_s;
    logic        accept_s;
    logic        hit_s;
    logic        step_s;
    logic        allzero_s;
    logic        shift_s;

    // Select the chunk under inspection (idx 3 = bits 63:48).
    always_comb begin
        chunk_s = 16'd0;
        case (idx_r)
            2'd3:    chunk_s = data_r[63:48];
            2'd2:    chunk_s = data_r[47:32];
            2'd1:    chunk_s = data_r[31:16];
            2'd0:    chunk_s = data_r[15:0];
            default: chunk_s = data_r[15:0];
        endcase
    end

    // Shared 16-bit leading-zero detector.
    always_comb begin
        lzc_s = lzc16(chunk_s);
    end

    // Next-state logic and per-cycle datapath strobes.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        hit_s      = 1'b0;
        step_s     = 1'b0;
        allzero_s  = 1'b0;
        shift_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s   = 1'b1;
                    state_nx_s = SCAN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SCAN: begin
`ifdef LZD64_ZERO_BYPASS_EN
                if (data_r == 64'd0) begin
                    allzero_s  = 1'b1;
                    state_nx_s = DONE;
                end else
`endif
                if (chunk_s != 16'd0) begin
                    hit_s      = 1'b1;
                    state_nx_s = SHIFT;
                end else if (idx_r != 2'd0) begin
                    step_s     = 1'b1;
                    state_nx_s = SCAN;
                end else begin
                    // Last chunk also zero: no shift needed.
                    allzero_s  = 1'b1;
                    state_nx_s = DONE;
                end
            end
            SHIFT: begin
                shift_s    = 1'b1;
                state_nx_s = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State register plus handshake/status flags registered from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
            busy_r      <= (state_nx_s != IDLE);
        end
    end

    // Operand capture, scan accumulator and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r      <= 64'd0;
            idx_r       <= 2'd3;
            count_r     <= 7'd0;
            out_count_r <= 7'd0;
            out_norm_r  <= 64'd0;
            out_zero_r  <= 1'b0;
        end else if (accept_s) begin
            data_r  <= in_data;
            idx_r   <= 2'd3;
            count_r <= 7'd0;
        end else if (hit_s) begin
            count_r <= count_r + {2'b00, lzc_s};
        end else if (step_s) begin
            count_r <= count_r + 7'd16;
            idx_r   <= idx_r - 2'd1;
        end else if (allzero_s) begin
            count_r     <= 7'd64;
            out_count_r <= 7'd64;
            out_norm_r  <= 64'd0;
            out_zero_r  <= 1'b1;
        end else if (shift_s) begin
            // count_r is at most 63 here, so the MSB of the result is set.
            out_norm_r  <= data_r << count_r;
            out_count_r <= count_r;
            out_zero_r  <= 1'b0;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_count = out_count_r;
    assign out_norm  = out_norm_r;
    assign out_zero  = out_zero_r;

endmodule
